sram_like_arbiter: RTL

- Shares one sram-like memory master port between two sram-like requesters: instruction fetch (inst_*) and load/store (data_*).
- Sits between the fetch/memory pipeline stages and the sram-like-to-bus bridge.
- Tracks owners of in-flight transactions in order and returns each data_ok/rdata to the requester that issued it.
- Fixed data-over-inst priority by default; the grant is locked while a forwarded request waits for addr_ok.

---
 rtl/sram_like_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram-like master port between fetch and load/store requesters.
// Define ARB_ROUND_ROBIN_EN for alternating grants; the default build gives data fixed priority.
module sram_like_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int OWNER_PTR_W     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int DEPTH = 1 << OWNER_PTR_W;

    typedef enum logic [1:0] {IDLE, HOLD_INST, HOLD_DATA} state_t;

    state_t                 state_q, state_d;
    logic [DEPTH-1:0]       owner_q, owner_d;
    logic [OWNER_PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   full, empty, idle_data, gnt_inst, gnt_data, push, pop;
`ifdef ARB_ROUND_ROBIN_EN
    logic                   last_grant_q, last_grant_d;
`endif

    function automatic logic [OWNER_PTR_W-1:0] nxt(input logic [OWNER_PTR_W-1:0] p);
        return (p == OWNER_PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + OWNER_PTR_W'(1);
    endfunction

    always_comb begin
        full  = count_q == CNT_W'(MAX_OUTSTANDING);
        empty = count_q == '0;
`ifdef ARB_ROUND_ROBIN_EN
        idle_data = data_req && (!inst_req || !last_grant_q);
`else
        idle_data = data_req;
`endif
        gnt_data = (state_q == HOLD_DATA) ? data_req : (state_q == HOLD_INST) ? 1'b0 : idle_data;
        gnt_inst = (state_q == HOLD_INST) ? inst_req : (state_q == HOLD_DATA) ? 1'b0 : inst_req && !idle_data;
        mem_req   = (gnt_inst || gnt_data) && !full;
        mem_wr    = gnt_data ? data_wr    : gnt_inst ? inst_wr    : 1'b0;
        mem_size  = gnt_data ? data_size  : gnt_inst ? inst_size  : 2'b0;
        mem_addr  = gnt_data ? data_addr  : gnt_inst ? inst_addr  : 32'b0;
        mem_wstrb = gnt_data ? data_wstrb : gnt_inst ? inst_wstrb : 4'b0;
        mem_wdata = gnt_data ? data_wdata : gnt_inst ? inst_wdata : 32'b0;
        push = mem_req && mem_addr_ok;
        pop  = mem_data_ok && !empty;
        inst_addr_ok = gnt_inst && push;
        data_addr_ok = gnt_data && push;
        inst_data_ok = pop && !owner_q[rd_ptr_q];
        data_data_ok = pop && owner_q[rd_ptr_q];
        inst_rdata = mem_rdata;
        data_rdata = mem_rdata;
        // a dropped request in a hold state releases the lock as well as an accept
        state_d = state_q;
        if (state_q == IDLE) begin
            if (mem_req && !mem_addr_ok)
                state_d = gnt_data ? HOLD_DATA : HOLD_INST;
        end else if (!(gnt_inst || gnt_data) || push) begin
            state_d = IDLE;
        end
        owner_d = owner_q;
        if (push)
            owner_d[wr_ptr_q] = gnt_data;
        wr_ptr_d = push ? nxt(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? nxt(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = push ? !last_grant_q : last_grant_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end
endmodule
